// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA sequencer and its datapath core.
package ula_pkg;

   localparam int ULA_WIDTH = 8;
   localparam int ULA_OP_W  = 3;

   // Opcode encoding on the request bus; codes above OP_MUL are illegal.
   typedef enum logic [ULA_OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_MUL = 3'd4
   } ula_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } ula_state_t;

   // True when an opcode has no defined operation.
   function automatic logic op_is_illegal(input logic [ULA_OP_W-1:0] op);
      return op > ULA_OP_W'(OP_MUL);
   endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational ULA datapath: ripple adder/subtractor built from full-adder
// cells plus bitwise AND/OR. SUB is A - B - CIN with COUT as borrow-out.

// Single-bit structural full adder.
module ula_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   logic w_p;

   assign w_p    = i_a ^ i_b;
   assign o_s    = w_p ^ i_cin;
   assign o_cout = (i_a & i_b) | (w_p & i_cin);
endmodule

module ula_core
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH
) (
   input  ula_op_t          i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_y,
   output logic             o_cout
);
   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_sum;

   // Subtraction reuses the adder as A + ~B + ~borrow_in.
   assign w_sub   = (i_op == OP_SUB);
   assign w_b_eff = w_sub ? ~i_b : i_b;
   assign w_c[0]  = w_sub ? ~i_cin : i_cin;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      ula_fa u_fa (
         .i_a    (i_a[g]),
         .i_b    (w_b_eff[g]),
         .i_cin  (w_c[g]),
         .o_s    (w_sum[g]),
         .o_cout (w_c[g+1])
      );
   end

   // Result select; carry is only meaningful for the arithmetic ops.
   always_comb begin
      o_y    = '0;
      o_cout = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_y    = w_sum;
            o_cout = w_c[WIDTH];
         end
         OP_SUB: begin
            o_y    = w_sum;
            o_cout = ~w_c[WIDTH];
         end
         OP_AND: o_y = i_a & i_b;
         OP_OR:  o_y = i_a | i_b;
         default: begin
            o_y    = '0;
            o_cout = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/ula_sequencer.sv
// Multi-cycle controller in front of a single shared ULA core.
// One request per input handshake; MUL runs as WIDTH shift-and-add steps.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; operands latched on accept
//   EXEC    | single-cycle op (ADD/SUB/AND/OR/illegal) through the core
//   MUL     | one shift-and-add step per cycle on the shared adder
//   DONE    | result valid, held until the output handshake
module ula_sequencer
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH,
   parameter int OP_W  = ULA_OP_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [OP_W-1:0]    i_in_op,
   input  logic [WIDTH-1:0]   i_in_a,
   input  logic [WIDTH-1:0]   i_in_b,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [2*WIDTH-1:0] o_out_res,
   output logic               o_out_carry,
   output logic               o_out_zero,
   output logic               o_out_err,
   output logic               o_busy
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   ula_state_t         r_state;
   ula_state_t         w_state_n;
   logic [OP_W-1:0]    r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_res;
   logic               r_carry;
   logic               r_zero;
   logic               r_err;

   logic               w_accept;
   logic               w_is_mul;
   logic               w_last_step;
   logic               w_illegal;
   ula_op_t            w_core_op;
   logic [WIDTH-1:0]   w_core_a;
   logic [WIDTH-1:0]   w_core_b;
   logic [WIDTH-1:0]   w_core_y;
   logic               w_core_cout;
   logic [WIDTH:0]     w_psum;
   logic [WIDTH-1:0]   w_acc_hi_n;
   logic [WIDTH-1:0]   w_mplier_n;

   assign o_in_ready  = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_out_valid = (r_state == ST_DONE);
   assign o_out_res   = r_res;
   assign o_out_carry = r_carry;
   assign o_out_zero  = r_zero;
   assign o_out_err   = r_err;

   assign w_accept    = i_in_valid & o_in_ready;
   assign w_is_mul    = (i_in_op == OP_W'(OP_MUL));
   assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_illegal   = op_is_illegal(ULA_OP_W'(r_op));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_n;
   end

   // Next-state logic.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_n = w_is_mul ? ST_MUL : ST_EXEC;
         ST_EXEC: w_state_n = ST_DONE;
         ST_MUL:  if (w_last_step) w_state_n = ST_DONE;
         ST_DONE: if (i_out_ready) w_state_n = ST_IDLE;
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Core operand routing: MUL steps add the multiplicand into the upper accumulator.
   always_comb begin
      w_core_op = ula_op_t'(r_op);
      w_core_a  = r_a;
      w_core_b  = r_b;
      if (r_state == ST_MUL) begin
         w_core_op = OP_ADD;
         w_core_a  = r_acc_hi;
         w_core_b  = r_a;
      end
   end

   ula_core #(.WIDTH(WIDTH)) u_core (
      .i_op   (w_core_op),
      .i_a    (w_core_a),
      .i_b    (w_core_b),
      .i_cin  (1'b0),
      .o_y    (w_core_y),
      .o_cout (w_core_cout)
   );

   // One multiply step: conditional add, then shift {carry, acc_hi, mplier} right.
   always_comb begin
      w_psum     = r_b[0] ? {w_core_cout, w_core_y} : {1'b0, r_acc_hi};
      w_acc_hi_n = w_psum[WIDTH:1];
      w_mplier_n = {w_psum[0], r_b[WIDTH-1:1]};
   end

   // Operand, accumulator, step counter and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc_hi <= '0;
         r_cnt    <= '0;
         r_res    <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op     <= i_in_op;
                  r_a      <= i_in_a;
                  r_b      <= i_in_b;
                  r_acc_hi <= '0;
                  r_cnt    <= '0;
               end
            end
            ST_EXEC: begin
               if (w_illegal) begin
                  r_res   <= '0;
                  r_carry <= 1'b0;
                  r_zero  <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  r_res   <= {{WIDTH{1'b0}}, w_core_y};
                  r_carry <= w_core_cout;
                  r_zero  <= (w_core_y == '0);
                  r_err   <= 1'b0;
               end
            end
            ST_MUL: begin
               r_acc_hi <= w_acc_hi_n;
               r_b      <= w_mplier_n;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last_step) begin
                  r_res   <= {w_acc_hi_n, w_mplier_n};
                  r_carry <= (w_acc_hi_n != '0);
                  r_zero  <= ({w_acc_hi_n, w_mplier_n} == '0);
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer: hand-computed results, latency,
// backpressure hold and mid-multiply reset.
`timescale 1ns/1ps
module tb_ula_sequencer;
   logic        clk_sys;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_res;
   logic        out_carry;
   logic        out_zero;
   logic        out_err;
   logic        busy;

   int n_total = 0;
   int n_bad   = 0;

   ula_sequencer dut (
      .i_clk       (clk_sys),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_op     (in_op),
      .i_in_a      (in_a),
      .i_in_b      (in_b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_res   (out_res),
      .o_out_carry (out_carry),
      .o_out_zero  (out_zero),
      .o_out_err   (out_err),
      .o_busy      (busy)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue a request, count edges until OUT_VALID, check result, then consume it.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] e_res, input logic e_carry,
                         input logic e_zero, input logic e_err, input int e_lat);
      int lat;
      @(negedge clk_sys);
      chk({tag, ".rdy"}, in_ready, 1'b1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(posedge clk_sys);
      #1;
      in_valid = 1'b0; in_op = 3'd0; in_a = 8'hxx; in_b = 8'hxx;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk_sys);
         #1;
         lat++;
      end
      chk({tag, ".lat"},   lat,       e_lat);
      chk({tag, ".res"},   out_res,   e_res);
      chk({tag, ".carry"}, out_carry, e_carry);
      chk({tag, ".zero"},  out_zero,  e_zero);
      chk({tag, ".err"},   out_err,   e_err);
      @(negedge clk_sys);
      out_ready = 1'b1;
      @(posedge clk_sys);
      #1;
      out_ready = 1'b0;
      chk({tag, ".idle"}, busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      rst = 1'b0;
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.res",   out_res,   16'h0000);
      chk("rst.zero",  out_zero,  1'b0);
      chk("rst.ready", in_ready,  1'b1);
      chk("rst.busy",  busy,      1'b0);

      //      tag        op    a      b      res       c     z     e     lat
      run_op("add200",  3'd0, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1'b0, 1);
      run_op("add_wrap", 3'd0, 8'd255, 8'd1,  16'h0000, 1'b1, 1'b1, 1'b0, 1);
      run_op("sub5_9",  3'd1, 8'd5,   8'd9,   16'h00FC, 1'b1, 1'b0, 1'b0, 1);
      run_op("sub9_9",  3'd1, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 1'b0, 1);

      // Reset while the multiplier is at step 4; nothing must come out.
      @(negedge clk_sys);
      in_valid = 1'b1; in_op = 3'd4; in_a = 8'd15; in_b = 8'd17;
      @(posedge clk_sys);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b1;
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      chk("mrst.valid", out_valid, 1'b0);
      chk("mrst.res",   out_res,   16'h0000);
      chk("mrst.carry", out_carry, 1'b0);
      chk("mrst.zero",  out_zero,  1'b0);
      chk("mrst.err",   out_err,   1'b0);
      chk("mrst.ready", in_ready,  1'b1);
      chk("mrst.busy",  busy,      1'b0);
      repeat (10) @(posedge clk_sys);
      #1;
      chk("mrst.quiet", out_valid, 1'b0);
      run_op("add3_4",  3'd0, 8'd3,   8'd4,   16'h0007, 1'b0, 1'b0, 1'b0, 1);

      run_op("mul15_17", 3'd4, 8'd15, 8'd17,  16'h00FF, 1'b0, 1'b0, 1'b0, 8);
      run_op("mul255",  3'd4, 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b0, 1'b0, 8);
      run_op("mul0",    3'd4, 8'd0,   8'd200, 16'h0000, 1'b0, 1'b1, 1'b0, 8);
      run_op("mul200_3", 3'd4, 8'd200, 8'd3,  16'h0258, 1'b1, 1'b0, 1'b0, 8);

      // Backpressure: result held while OUT_READY low; a competing request is refused.
      @(negedge clk_sys);
      in_valid = 1'b1; in_op = 3'd0; in_a = 8'd1; in_b = 8'd1;
      @(posedge clk_sys);
      #1;
      in_op = 3'd2; in_a = 8'h00; in_b = 8'h00;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_sys);
         #1;
         if (i > 0) begin
            chk("bp.valid", out_valid, 1'b1);
            chk("bp.res",   out_res,   16'h0002);
            chk("bp.ready", in_ready,  1'b0);
            chk("bp.busy",  busy,      1'b1);
         end
      end
      in_valid = 1'b0;
      @(negedge clk_sys);
      out_ready = 1'b1;
      @(posedge clk_sys);
      #1;
      chk("bp.idle",  busy,      1'b0);
      chk("bp.rdy",   in_ready,  1'b1);
      chk("bp.vdrop", out_valid, 1'b0);
      // OUT_READY left high across an idle cycle must not matter.
      @(posedge clk_sys);
      #1;
      out_ready = 1'b0;
      chk("bp.still_idle", busy, 1'b0);

      run_op("illegal6", 3'd6, 8'd1,   8'd1,   16'h0000, 1'b0, 1'b1, 1'b1, 1);
      run_op("and",     3'd2, 8'hF0, 8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0, 1);
      run_op("or",      3'd3, 8'hF0, 8'h0F,  16'h00FF, 1'b0, 1'b0, 1'b0, 1);
      run_op("illegal7", 3'd7, 8'hFF, 8'hFF,  16'h0000, 1'b0, 1'b1, 1'b1, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
